// File: rtl/axis_sa_requant_if.sv
// AXI-Stream style beat bus carrying N packed lanes of W bits each.
// The same interface type serves both the wide input side and the narrowed output side.
interface axis_sa_requant_if #(
  parameter int N = 4,
  parameter int W = 16
);
  logic               valid;
  logic               ready;
  logic               last;
  logic [N-1:0][W-1:0] data;

  modport master (output valid, output last, output data, input ready);
  modport slave  (input valid, input last, input data, output ready);
endinterface

// File: rtl/axis_sa_requant.sv
// Requantizer behind the systolic array: per-packet round-half-up arithmetic shift,
// saturation to WO bits, optional ReLU, and a sticky packet-length check.
module axis_sa_requant #(
  parameter int R  = 4,
  parameter int C  = 8,
  parameter int WY = 16,
  parameter int WO = 8,
  parameter int WS = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  axis_sa_requant_if.slave         s_axis,
  axis_sa_requant_if.master        m_axis,
  input  logic [WS-1:0]            shift,
  input  logic                     relu_en,
  output logic                     len_err
);

  localparam int SHW = (WY > 1) ? $clog2(WY) : 1;
  localparam int CW  = (C > 1) ? $clog2(C) : 1;
  localparam logic [CW-1:0]        CNT_LAST = CW'(C - 1);
  localparam logic [SHW-1:0]       SH_MAX   = SHW'(WY - 1);
  localparam logic signed [WY:0]   OUT_MAX  = (WY+1)'((1 << (WO - 1)) - 1);
  localparam logic signed [WY:0]   OUT_MIN  = ~OUT_MAX;

  function automatic logic [SHW-1:0] clamp_shift(input logic [WS-1:0] s);
    if (int'(s) > WY - 1) begin
      clamp_shift = SH_MAX;
    end else begin
      clamp_shift = SHW'(s);
    end
  endfunction

  // One extra bit of headroom keeps x + 2^(s-1) exact for every s <= WY-1.
  function automatic logic signed [WY:0] round_shift(input logic signed [WY-1:0] x,
                                                     input logic [SHW-1:0] s);
    logic signed [WY:0] xe;
    logic signed [WY:0] rnd;
    xe = {x[WY-1], x};
    if (s == SHW'(0)) begin
      round_shift = xe;
    end else begin
      rnd         = (WY+1)'(1) << (s - SHW'(1));
      round_shift = (xe + rnd) >>> s;
    end
  endfunction

  function automatic logic [WO-1:0] sat_relu(input logic signed [WY:0] t, input logic rl);
    logic [WO-1:0] y;
    if (t > OUT_MAX) begin
      y = OUT_MAX[WO-1:0];
    end else if (t < OUT_MIN) begin
      y = OUT_MIN[WO-1:0];
    end else begin
      y = t[WO-1:0];
    end
    if (rl && y[WO-1]) begin
      sat_relu = '0;
    end else begin
      sat_relu = y;
    end
  endfunction

  logic                  en1_s;
  logic                  en2_s;
  logic                  acc_s;
  logic [SHW-1:0]        sh_eff_s;
  logic                  relu_eff_s;
  logic signed [WY:0]    t_next_s [R];

  logic                  first_r;
  logic [WS-1:0]         shift_q_r;
  logic                  relu_q_r;
  logic [CW-1:0]         cnt_r;
  logic                  len_err_r;

  logic                  v1_r;
  logic                  last1_r;
  logic                  relu1_r;
  logic signed [WY:0]    t1_r [R];

  logic                  v2_r;
  logic                  last2_r;
  logic [R-1:0][WO-1:0]  y2_r;

  // Stage enables: a stage may load when it is empty or its contents move on.
  always_comb begin
    en2_s = !v2_r || m_axis.ready;
    en1_s = !v1_r || en2_s;
    acc_s = s_axis.valid && en1_s;
  end

  // Packet parameters come straight from the ports on a packet's first beat.
  always_comb begin
    if (first_r) begin
      sh_eff_s   = clamp_shift(shift);
      relu_eff_s = relu_en;
    end else begin
      sh_eff_s   = clamp_shift(shift_q_r);
      relu_eff_s = relu_q_r;
    end
  end

  // Per-lane rounding shift of the incoming beat.
  always_comb begin
    for (int i = 0; i < R; i++) begin
      t_next_s[i] = round_shift(s_axis.data[i], sh_eff_s);
    end
  end

  assign s_axis.ready = en1_s;
  assign m_axis.valid = v2_r;
  assign m_axis.last  = last2_r;
  assign m_axis.data  = y2_r;
  assign len_err      = len_err_r;

  // Packet-start flag and latched per-packet parameters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      first_r   <= 1'b1;
      shift_q_r <= '0;
      relu_q_r  <= 1'b0;
    end else if (acc_s) begin
      first_r <= s_axis.last;
      if (first_r) begin
        shift_q_r <= shift;
        relu_q_r  <= relu_en;
      end
    end
  end

  // Beat counter and sticky length-error flag; a runaway packet wraps every C beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r     <= '0;
      len_err_r <= 1'b0;
    end else if (acc_s) begin
      if (s_axis.last) begin
        cnt_r <= '0;
        if (cnt_r != CNT_LAST) begin
          len_err_r <= 1'b1;
        end
      end else if (cnt_r == CNT_LAST) begin
        cnt_r     <= '0;
        len_err_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // S1: holds the rounded, shifted lanes together with the beat's relu and last.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_r    <= 1'b0;
      last1_r <= 1'b0;
      relu1_r <= 1'b0;
      for (int i = 0; i < R; i++) begin
        t1_r[i] <= '0;
      end
    end else if (en1_s) begin
      v1_r <= acc_s;
      if (acc_s) begin
        last1_r <= s_axis.last;
        relu1_r <= relu_eff_s;
        for (int i = 0; i < R; i++) begin
          t1_r[i] <= t_next_s[i];
        end
      end
    end
  end

  // S2: saturated, ReLU-applied output beat; frozen while the sink stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2_r    <= 1'b0;
      last2_r <= 1'b0;
      y2_r    <= '0;
    end else if (en2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        last2_r <= last1_r;
        for (int i = 0; i < R; i++) begin
          y2_r[i] <= sat_relu(t1_r[i], relu1_r);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_sa_requant.sv
// Scoreboard bench for axis_sa_requant: directed and random packets against an
// arithmetic reference model, with a decoupled output monitor.
module tb_axis_sa_requant;
  localparam int R  = 4;
  localparam int C  = 8;
  localparam int WY = 16;
  localparam int WO = 8;
  localparam int WS = 5;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic [WS-1:0] shift;
  logic relu_en;
  logic len_err;

  axis_sa_requant_if #(.N(R), .W(WY)) s_if ();
  axis_sa_requant_if #(.N(R), .W(WO)) m_if ();

  axis_sa_requant #(.R(R), .C(C), .WY(WY), .WO(WO), .WS(WS)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_axis  (s_if),
    .m_axis  (m_if),
    .shift   (shift),
    .relu_en (relu_en),
    .len_err (len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [R-1:0][WO-1:0] data;
    logic                 last;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    n_acc = 0;
  bit    rand_ready = 1'b0;

  bit    mdl_first = 1'b1;
  int    mdl_shift = 0;
  bit    mdl_relu = 1'b0;
  int    mdl_pos = 0;
  bit    mdl_len_err = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Exact rational rounding: floor((x + 2^(s-1)) / 2^s), then clip and ReLU.
  function automatic int ref_lane(input int x, input int s_in, input bit rl);
    int s, t, num, d;
    s = (s_in > WY - 1) ? WY - 1 : s_in;
    if (s == 0) begin
      t = x;
    end else begin
      d   = 1 << s;
      num = x + d / 2;
      t   = num / d;
      if ((num % d) != 0 && num < 0) t = t - 1;
    end
    if (t > (1 << (WO - 1)) - 1) t = (1 << (WO - 1)) - 1;
    if (t < -(1 << (WO - 1))) t = -(1 << (WO - 1));
    if (rl && t < 0) t = 0;
    return t;
  endfunction

  function automatic logic [R-1:0][WY-1:0] lanes4(input int a, input int b, input int c, input int d);
    logic [R-1:0][WY-1:0] v;
    v[0] = WY'(a);
    v[1] = WY'(b);
    v[2] = WY'(c);
    v[3] = WY'(d);
    return v;
  endfunction

  function automatic logic [R-1:0][WY-1:0] lanes_all(input int a);
    return lanes4(a, a, a, a);
  endfunction

  function automatic logic [R-1:0][WY-1:0] lanes_rand();
    logic [R-1:0][WY-1:0] v;
    for (int i = 0; i < R; i++) begin
      if ($urandom_range(0, 1) == 0) v[i] = WY'($urandom);
      else v[i] = WY'(int'($urandom_range(0, 1200)) - 600);
    end
    return v;
  endfunction

  task automatic model_accept(input logic [R-1:0][WY-1:0] d, input bit lst, input int sh, input bit rl);
    beat_t e;
    if (mdl_first) begin
      mdl_shift = sh;
      mdl_relu  = rl;
    end
    for (int i = 0; i < R; i++) begin
      e.data[i] = WO'(ref_lane(int'($signed(d[i])), mdl_shift, mdl_relu));
    end
    e.last = lst;
    exp_q.push_back(e);
    mdl_pos++;
    if (lst) begin
      if (mdl_pos % C != 0) mdl_len_err = 1'b1;
      mdl_pos = 0;
    end else if (mdl_pos % C == 0) begin
      mdl_len_err = 1'b1;
    end
    mdl_first = lst;
    n_acc++;
  endtask

  task automatic send_beat(input logic [R-1:0][WY-1:0] d, input bit lst, input int sh, input bit rl);
    bit acc;
    int waited;
    acc = 1'b0;
    waited = 0;
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.last  = lst;
    shift      = WS'(sh);
    relu_en    = rl;
    while (!acc && waited < 60) begin
      @(negedge clk);
      acc = s_if.ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (acc) begin
      model_accept(d, lst, sh, rl);
      check("len_err_track", 64'(len_err), 64'(mdl_len_err));
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: s_ready stayed 0 for %0d cycles, required 1", waited);
    end
  endtask

  task automatic idle();
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_if.valid) && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    #1;
    check("rst_s_ready", 64'(s_if.ready), 64'd1);
    check("rst_m_valid", 64'(m_if.valid), 64'd0);
    check("rst_m_last",  64'(m_if.last), 64'd0);
    check("rst_m_data",  64'(m_if.data), 64'd0);
    check("rst_len_err", 64'(len_err), 64'd0);
    exp_q.delete();
    mdl_first = 1'b1;
    mdl_shift = 0;
    mdl_relu = 1'b0;
    mdl_pos = 0;
    mdl_len_err = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      m_if.ready = ($urandom_range(0, 2) != 0);
    end
  end

  logic [R-1:0][WO-1:0] held_data;
  logic                 held_last;
  bit                   held = 1'b0;

  // Output monitor: scoreboard pops on each transfer, stall stability between them.
  always @(negedge clk) begin
    if (!rstn) begin
      held = 1'b0;
    end else begin
      if (m_if.valid && held) begin
        check("stall_data", 64'(m_if.data), 64'(held_data));
        check("stall_last", 64'(m_if.last), 64'(held_last));
      end
      if (m_if.valid && m_if.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data 0x%0h, required no output", m_if.data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_data", 64'(m_if.data), 64'(e.data));
          check("out_last", 64'(m_if.last), 64'(e.last));
        end
        held = 1'b0;
      end else if (m_if.valid) begin
        held      = 1'b1;
        held_data = m_if.data;
        held_last = m_if.last;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  int base;

  initial begin
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    s_if.data  = '0;
    shift      = '0;
    relu_en    = 1'b0;
    m_if.ready = 1'b1;
    #2;
    do_reset();

    // Rounding and output latency of a lone beat.
    send_beat(lanes4(300, -300, 6, -6), 1'b1, 2, 1'b0);
    idle();
    check("lat_after_s1", 64'(m_if.valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_after_s2", 64'(m_if.valid), 64'd1);
    wait_drain();

    // Saturation, ReLU and shift clamp.
    send_beat(lanes4(1000, -1000, 32767, -32768), 1'b1, 2, 1'b0);
    send_beat(lanes4(1000, -1000, 32767, -32768), 1'b1, 2, 1'b1);
    send_beat(lanes4(32767, -32768, 100, -16384), 1'b1, 31, 1'b0);
    send_beat(lanes4(127, -129, 5, -5), 1'b1, 0, 1'b1);
    idle();
    wait_drain();
    check("len_err_single_beats", 64'(len_err), 64'd1);

    do_reset();

    // Per-packet parameter latch; later beats drive a different shift.
    for (int b = 0; b < C; b++) send_beat(lanes_all(10), b == C - 1, (b == 0) ? 1 : 4, 1'b0);
    for (int b = 0; b < C; b++) send_beat(lanes_all(10), b == C - 1, 4, 1'b0);
    idle();
    wait_drain();

    // Backpressure: two beats fill the pipeline, then everything flows without gaps.
    m_if.ready = 1'b0;
    base = n_acc;
    fork
      begin
        for (int b = 0; b < C; b++) send_beat(lanes_rand(), b == C - 1, 3, 1'b0);
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        check("bp_accepted", 64'(n_acc - base), 64'd2);
        check("bp_s_ready", 64'(s_if.ready), 64'd0);
        m_if.ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("bp_no_gap", 64'(m_if.valid), 64'd1);
        end
      end
    join
    wait_drain();
    check("bp_s_ready_back", 64'(s_if.ready), 64'd1);

    // Random well-formed packets under random sink backpressure.
    rand_ready = 1'b1;
    for (int p = 0; p < 20; p++) begin
      int  sh0;
      bit  rl0;
      sh0 = int'($urandom_range(0, 31));
      rl0 = 1'($urandom_range(0, 1));
      for (int b = 0; b < C; b++) begin
        if ($urandom_range(0, 4) == 0) begin
          idle();
          @(posedge clk);
          #1;
        end
        if (b == 0) send_beat(lanes_rand(), 1'b0, sh0, rl0);
        else send_beat(lanes_rand(), b == C - 1, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end
    end
    idle();
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    m_if.ready = 1'b1;
    wait_drain();
    check("len_err_clean", 64'(len_err), 64'd0);

    // Short packet: last on beat 5.
    for (int b = 0; b < 6; b++) send_beat(lanes_all(-77), b == 5, 1, 1'b0);
    idle();
    check("len_err_short", 64'(len_err), 64'd1);
    wait_drain();

    // Runaway packet: error flagged at the 8th beat without last.
    do_reset();
    for (int b = 0; b < C + 1; b++) begin
      send_beat(lanes_all(b * 40), 1'b0, 2, 1'b0);
      if (b == C - 2) check("len_err_beat7", 64'(len_err), 64'd0);
      if (b == C - 1) check("len_err_beat8", 64'(len_err), 64'd1);
    end
    idle();
    wait_drain();

    // Reset with the pipeline full in the middle of a packet.
    m_if.ready = 1'b0;
    send_beat(lanes_all(200), 1'b0, 3, 1'b0);
    send_beat(lanes_all(201), 1'b0, 3, 1'b0);
    s_if.valid = 1'b1;
    s_if.data  = lanes_all(202);
    @(posedge clk);
    #3;
    check("pre_rst_full", 64'(m_if.valid), 64'd1);
    do_reset();
    m_if.ready = 1'b1;
    for (int b = 0; b < C; b++) send_beat(lanes_all(10), b == C - 1, (b == 0) ? 1 : 6, 1'b0);
    idle();
    wait_drain();
    check("post_rst_len_err", 64'(len_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
